// File: rtl/lamp_pwm_if.sv
// Lamp PWM control/status bundle: run enable and duty request in, lamp drive and status out.
interface lamp_pwm_if;
  logic       enable;
  logic [9:0] duty_in;
  logic       pwm_out;
  logic [9:0] duty_active;
  logic       period_start;

  modport master (output enable, duty_in, input pwm_out, duty_active, period_start);
  modport slave  (input enable, duty_in, output pwm_out, duty_active, period_start);
endinterface

// File: rtl/lamp_pwm_generator.sv
// Glitch-free brake lamp PWM; duty is latched only at period boundaries.
// Optional soft ramp of the duty when LAMP_PWM_RAMP_EN is defined.
module lamp_pwm_generator #(
  parameter int PRESCALE  = 49,
  parameter int RAMP_STEP = 64
) (
  input logic        CLOCK_50,
  input logic        reset_n,
  lamp_pwm_if.slave  pwm_if
);

  localparam int            PW      = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE);

  if (PRESCALE < 0 || RAMP_STEP < 1 || RAMP_STEP > 1023) begin : g_bad_param
    $error("lamp_pwm_generator: PRESCALE must be >= 0 and RAMP_STEP in 1..1023");
  end

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [9:0]    duty_active_q, duty_active_d;
  logic          started_q, started_d;
  logic          period_start_q, period_start_d;
  logic          pwm_q, pwm_d;
  logic          tick, load;
  logic [9:0]    next_duty;

  assign tick = pwm_if.enable && (pre_cnt_q == PRE_MAX);
  assign load = pwm_if.enable && ((tick && cnt_q == 10'h3FF) || !started_q);

`ifdef LAMP_PWM_RAMP_EN
  localparam logic [10:0] STEP11 = 11'(RAMP_STEP);
  logic [10:0] tgt, cur, diff, nd11;

  // duty_active is 0 whenever started is low, so the first load ramps from 0.
  always_comb begin
    tgt  = {1'b0, pwm_if.duty_in};
    cur  = {1'b0, duty_active_q};
    diff = '0;
    nd11 = tgt;
    if (tgt >= cur) begin
      diff = tgt - cur;
      if (diff > STEP11) nd11 = cur + STEP11;
    end else begin
      diff = cur - tgt;
      if (diff > STEP11) nd11 = cur - STEP11;
    end
    next_duty = nd11[9:0];
  end
`else
  assign next_duty = pwm_if.duty_in;
`endif

  always_comb begin
    pre_cnt_d      = pre_cnt_q;
    cnt_d          = cnt_q;
    duty_active_d  = duty_active_q;
    started_d      = started_q;
    period_start_d = 1'b0;
    pwm_d          = 1'b0;
    if (!pwm_if.enable) begin
      pre_cnt_d     = '0;
      cnt_d         = '0;
      duty_active_d = '0;
      started_d     = 1'b0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
      if (tick) cnt_d = cnt_q + 10'd1;
      if (load) begin
        duty_active_d  = next_duty;
        started_d      = 1'b1;
        period_start_d = 1'b1;
      end
      // Full scale is held solid high rather than 1023/1024.
      pwm_d = started_q && (duty_active_q == 10'h3FF || cnt_q < duty_active_q);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      duty_active_q  <= '0;
      started_q      <= 1'b0;
      period_start_q <= 1'b0;
      pwm_q          <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      duty_active_q  <= duty_active_d;
      started_q      <= started_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
    end
  end

  assign pwm_if.pwm_out      = pwm_q;
  assign pwm_if.duty_active  = duty_active_q;
  assign pwm_if.period_start = period_start_q;

endmodule
